// File: rtl/ysyx22041405_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one request in flight to
// instruction memory, and presents each fetched instruction to IF/ID until it is
// taken. A redirect always wins: it reloads the PC and squashes any in-flight fetch.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, nothing issued yet
// REQ   | request for pc presented to memory, waiting for acceptance
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction buffered and offered to IF/ID
// DRAIN | squashed request still outstanding, its response is discarded
module ysyx22041405_fetch_unit #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = 32'h8000_0000,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [2:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_buf_q, inst_buf_d;

  // Next-state logic: normal sequencing first, then a redirect overrides it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;

    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   if (imem_req_ready) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_buf_d = imem_rsp_data;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (if_ready) begin
          pc_d    = pc_q + STEP;
          state_d = S_REQ;
        end
      end
      S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inst_buf_d = inst_buf_q;
      case (state_q)
        S_IDLE, S_HOLD: state_d = S_REQ;
        // An accepted request cannot be recalled, so its response must be drained.
        S_REQ:          state_d = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT,
        S_DRAIN:        state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default:        state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_buf_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
    end
  end

  // Outputs come straight from registers; no input reaches an output combinationally.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == S_HOLD);
  assign if_pc          = pc_q;
  assign if_inst        = inst_buf_q;

endmodule

// File: doc/ysyx22041405_fetch_unit.md
# ysyx22041405_fetch_unit

Parametrised instruction-fetch stage that owns the PC, issues single-outstanding requests to instruction memory over a valid/ready channel, and hands fetched instructions to the IF/ID register over a valid/ready channel. It replaces the free-running PC incrementer: it supports a configurable reset vector and PC width, back-pressure from decode, stalls from memory, and branch/jump redirects that squash in-flight fetches.

## Interface
- XLEN, 32, width of PC, address and instruction data
- RESET_PC, 32'h8000_0000, PC value loaded on reset
- PC_STEP, 4, sequential PC increment
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- redirect_valid  in  1  redirect request from EXU/WBU (1-cycle pulse, may repeat)
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= current PC)
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  XLEN  fetched instruction
- if_valid  out  1  instruction valid to IF/ID
- if_ready  in  1  IF/ID accepts instruction
- if_pc  out  XLEN  PC of presented instruction
- if_inst  out  XLEN  presented instruction

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Reset -> IDLE; illegal encodings -> IDLE next cycle.
- Registers: pc, inst_buf, state. Reset values: pc=RESET_PC, inst_buf=0, state=IDLE; all outputs 0 except imem_req_addr=if_pc=RESET_PC.
- IDLE: outputs idle; -> REQ unconditionally.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
- WAIT: on imem_rsp_valid, inst_buf<=imem_rsp_data -> HOLD.
- HOLD: if_valid=1, if_pc=pc, if_inst=inst_buf (stable until handshake). On if_ready: pc<=pc+PC_STEP (mod 2^XLEN, wraps silently) -> REQ.
- DRAIN: wait for response of a squashed request; on imem_rsp_valid discard data -> REQ. No request issued in DRAIN.
- Redirect (redirect_valid=1) has priority over every other event; pc<=redirect_pc always. Next state:
  - IDLE or HOLD -> REQ (held instruction dropped even if if_ready=1 same cycle; no handshake counted).
  - REQ without imem_req_ready -> REQ (address changes to new pc next cycle; memory must tolerate withdrawn request).
  - REQ with imem_req_ready -> DRAIN.
  - WAIT without imem_rsp_valid -> DRAIN.
  - WAIT with imem_rsp_valid -> REQ (data dropped).
  - DRAIN -> DRAIN, or REQ if imem_rsp_valid same cycle.
- At most one request outstanding; imem_req_valid never asserted in WAIT, HOLD, DRAIN.
- rst mid-operation: all state to reset values next edge; a response arriving afterwards for a pre-reset request is ignored in IDLE (memory is expected to be reset together).

## Timing
- Reset deasserted before edge 0: IDLE at cycle 0, REQ at cycle 1.
- With imem_req_ready=1 and response one cycle after acceptance: req at cycle 1, rsp at cycle 2, if_valid at cycle 3.
- Steady-state throughput with zero stalls: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect penalty: new-target request appears the cycle after redirect when not draining; else the cycle after the squashed response.
- if_valid, if_pc, if_inst are registered; imem_req_valid/addr are decoded from registered state only (no combinational path from any input to any output).

## Test plan
- Reset and sequential fetch: rst 2 cycles, memory ready=1, 1-cycle latency, if_ready=1 -> if_pc 0x80000000, 0x80000004, 0x80000008 with if_valid at cycles 3, 6, 9.
- Back-pressure: if_ready=0 for 5 cycles in HOLD -> if_valid stays 1, if_pc/if_inst unchanged, no imem_req_valid; pc advances only after if_ready=1.
- Memory stall: imem_req_ready=0 for 4 cycles, then response delayed 3 cycles -> imem_req_addr stable at pc throughout, exactly one if_valid for that pc.
- Redirect in WAIT: redirect to 0x80001000 while awaiting response -> DRAIN, old response discarded (never seen on if_inst), next request addr 0x80001000.
- Redirect in HOLD with if_ready=1 same cycle -> no instruction consumed, pc=redirect_pc, next request addr = redirect_pc.
- Wrap and mid-op reset: RESET_PC=32'hFFFF_FFFC -> second fetch at 0x00000000; assert rst in WAIT -> state IDLE, if_valid=0, pc=RESET_PC next cycle.
